// File: rtl/display_pkg.sv
// Shared constants, digit index type and nibble helper for the 7-segment scan controller.
package display_pkg;

  // Segment patterns are [0:6] = a..g, active-low (common anode).
  localparam logic [0:6] SEG_0   = 7'b0000001;
  localparam logic [0:6] SEG_1   = 7'b1001111;
  localparam logic [0:6] SEG_2   = 7'b0010010;
  localparam logic [0:6] SEG_3   = 7'b0000110;
  localparam logic [0:6] SEG_4   = 7'b1001100;
  localparam logic [0:6] SEG_5   = 7'b0100100;
  localparam logic [0:6] SEG_6   = 7'b0100000;
  localparam logic [0:6] SEG_7   = 7'b0001111;
  localparam logic [0:6] SEG_8   = 7'b0000000;
  localparam logic [0:6] SEG_9   = 7'b0000100;
  localparam logic [0:6] SEG_A   = 7'b0001000;
  localparam logic [0:6] SEG_B   = 7'b1100000;
  localparam logic [0:6] SEG_C   = 7'b0110001;
  localparam logic [0:6] SEG_D   = 7'b1000010;
  localparam logic [0:6] SEG_E   = 7'b0110000;
  localparam logic [0:6] SEG_F   = 7'b0111000;
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] nibble_sel(input logic [15:0] value, input digit_idx_t n);
    return value[{n, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder, active-low outputs ordered [0:6] = a..g.
module seg7_hex_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scan controller with frame-aligned double buffering.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] data_in,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [0:6]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_tick
);

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  digit_idx_t       next_idx;
  logic             slot_tick;
  logic             frame_edge;
  logic [15:0]      shadow;
  logic [15:0]      active;
  logic [15:0]      active_next;
  logic [3:0]       dec_nibble;
  logic [0:6]       seg_dec;
  logic             visible;

  assign slot_tick   = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign next_idx    = idx + 2'd1;
  assign frame_edge  = slot_tick && (idx == 2'd3);
  // Outputs registered on a frame edge must already show the value committed on that edge.
  assign active_next = (frame_edge && pending) ? shadow : active;
  assign dec_nibble  = nibble_sel(active_next, next_idx);

  seg7_hex_decode u_dec (
    .nibble (dec_nibble),
    .seg    (seg_dec)
  );

  always_comb begin
    visible = digit_en[next_idx];
`ifdef LEADING_ZERO_BLANK_EN
    if ((next_idx != 2'd0) && ((active_next >> {next_idx, 2'b00}) == 16'd0))
      visible = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd3;
    end else if (slot_tick) begin
      cnt <= '0;
      idx <= next_idx;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A write on the frame edge lands in shadow after the old shadow has been committed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= 16'd0;
      active  <= 16'd0;
      pending <= 1'b0;
    end else begin
      if (frame_edge && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (wr_en) begin
        shadow  <= data_in;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_edge;
      if (slot_tick) begin
        an  <= visible ? ~(4'b0001 << next_idx) : AN_OFF;
        seg <= seg_dec;
        dp  <= ~dp_en[next_idx];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a cycle-count based reference model.
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_display_scan_ctrl;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] data_in;
  logic [3:0]  digit_en;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [0:6]  seg;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release plus the two buffers.
  int          k;
  logic [15:0] m_shad, m_act;
  logic        m_pend, m_ft, m_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [6:0]  seg_tbl [16];

  display_scan_ctrl #(.REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .digit_en   (digit_en),
    .dp_en      (dp_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic modelStep();
    int  n;
    logic vis;
    if (!rst_n) begin
      k = 0; m_shad = 16'd0; m_act = 16'd0; m_pend = 1'b0; m_ft = 1'b0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      k++;
      n = (k / R - 1) % 4;
      m_ft = (k % R == 0) && (n == 0);
      if (m_ft && m_pend) begin
        m_act  = m_shad;
        m_pend = 1'b0;
      end
      if (wr_en) begin
        m_shad = data_in;
        m_pend = 1'b1;
      end
      if (k % R == 0) begin
        vis = digit_en[n];
`ifdef LEADING_ZERO_BLANK_EN
        if (n > 0 && (int'(m_act) >> (4 * n)) == 0) vis = 1'b0;
`endif
        m_an  = vis ? (4'hF & ~(4'(1) << n)) : 4'hF;
        m_seg = seg_tbl[(int'(m_act) >> (4 * n)) & 15];
        m_dp  = ~dp_en[n];
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] d,
                               input logic [3:0] de, input logic [3:0] pe);
    rst_n = r; wr_en = w; data_in = d; digit_en = de; dp_en = pe;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("an", 32'(an), 32'(m_an));
    checkOutput("seg", 32'(seg), 32'(m_seg));
    checkOutput("dp", 32'(dp), 32'(m_dp));
    checkOutput("pending", 32'(pending), 32'(m_pend));
    checkOutput("frame_tick", 32'(frame_tick), 32'(m_ft));
  endtask

  task automatic idle(input int cycles, input logic [3:0] de, input logic [3:0] pe);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0, 16'h0, de, pe);
  endtask

  initial begin
    int tries;
    seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111; seg_tbl[2]  = 7'b0010010;
    seg_tbl[3]  = 7'b0000110; seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
    seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111; seg_tbl[8]  = 7'b0000000;
    seg_tbl[9]  = 7'b0000100; seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
    seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010; seg_tbl[14] = 7'b0110000;
    seg_tbl[15] = 7'b0111000;
    k = 0;
    rst_n = 1'b0; wr_en = 1'b0; data_in = 16'h0; digit_en = 4'hF; dp_en = 4'h0;

    applyStimulus(1'b0, 1'b0, 16'h0, 4'hF, 4'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'hF, 4'h0);
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_pending", 32'(pending), 32'h0);

    // Rotation after release, then a committed write.
    idle(3, 4'hF, 4'h0);
    checkOutput("pre_first_slot_an", 32'(an), 32'hF);
    idle(1, 4'hF, 4'h0);
    checkOutput("first_slot_an", 32'(an), 32'hE);
    idle(16, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b1, 16'h1230, 4'hF, 4'h0);
    idle(40, 4'hF, 4'h0);

    // Back-to-back writes within one frame: last write wins.
    applyStimulus(1'b1, 1'b1, 16'hAAAA, 4'hF, 4'h0);
    idle(2, 4'hF, 4'h0);
    applyStimulus(1'b1, 1'b1, 16'h3210, 4'hF, 4'h0);
    idle(40, 4'hF, 4'h0);

    // Write landing exactly on a frame-boundary edge.
    applyStimulus(1'b1, 1'b1, 16'h9876, 4'hF, 4'h0);
    tries = 0;
    while (!(((k + 1) % R == 0) && (((k + 1) / R - 1) % 4 == 0)) && tries < 4 * R) begin
      idle(1, 4'hF, 4'h0);
      tries++;
    end
    applyStimulus(1'b1, 1'b1, 16'h4567, 4'hF, 4'h0);
    checkOutput("boundary_write_pending", 32'(pending), 32'h1);
    checkOutput("boundary_write_ftick", 32'(frame_tick), 32'h1);
    idle(40, 4'hF, 4'h0);

    // Blanking and decimal point masks.
    idle(24, 4'b0101, 4'b0001);

    // Small values exercise leading-zero suppression when it is built in.
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'hF, 4'h3);
    idle(40, 4'hF, 4'h3);
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'hF, 4'h0);
    idle(40, 4'hF, 4'h0);

    // Reset mid-frame with a pending write discards it.
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 4'hF, 4'h0);
    idle(5, 4'hF, 4'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'hF, 4'h0);
    checkOutput("midreset_pending", 32'(pending), 32'h0);
    idle(40, 4'hF, 4'h0);

    for (int i = 0; i < 3000; i++) begin
      logic        r, w;
      logic [15:0] d;
      logic [3:0]  de;
      r = ($urandom_range(0, 399) != 0);
      w = ($urandom_range(0, 7) == 0);
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = d & 16'h00FF;
        1: d = d & 16'h0F0F;
        default: ;
      endcase
      de = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      applyStimulus(r, w, d, de, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the Basys 3 four-digit common-anode 7-segment display. It holds a 16-bit hex value and rotates one active-low anode per refresh slot. It drives one shared hex-to-segment decoder with the nibble of the active digit. Writes are double-buffered and committed only at frame boundaries, so the display never tears. The block sits between the user logic that produces the value and the board pins `an`, `seg` and `dp`.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles per digit slot (1 kHz per digit and 250 Hz per frame at 100 MHz); must be ≥ 2.
- `CNT_W`, default $clog2(REFRESH_DIV): width of the refresh counter; derived, not overridden.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  single-cycle write strobe for `data_in`.
- `data_in`  in  16  hex value; [15:12] = digit 3 (leftmost), [3:0] = digit 0 (rightmost).
- `digit_en`  in  4  per-digit enable; 0 blanks that digit.
- `dp_en`  in  4  per-digit decimal point request.
- `an`  out  4  anodes, active-low, one-hot-low or all high.
- `seg`  out  7  segments a..g as [0:6], active-low.
- `dp`  out  1  decimal point, active-low.
- `pending`  out  1  a written value is waiting for a frame boundary.
- `frame_tick`  out  1  one-cycle pulse per completed frame.

## Operation
- Refresh counter `cnt` counts 0..REFRESH_DIV-1 and wraps. `slot_tick` is asserted when `cnt == REFRESH_DIV-1`.
- Digit index `idx` (2 bits) advances on each `slot_tick`, wrapping 3→0. The wrap 3→0 is the frame boundary.
- Shadow register `shadow` and active register `active` are both 16 bits.
- `wr_en` writes `data_in` into `shadow` and sets `pending`.
- On a frame-boundary edge with `pending` = 1: `active` ← `shadow` and `pending` is cleared.
- If `wr_en` coincides with a frame-boundary edge:
  - `active` takes the old `shadow`.
  - The new data goes to `shadow`.
  - `pending` stays 1.
- Repeated writes before a boundary: last write wins and `pending` stays 1.
- On each `slot_tick` edge, outputs are registered for `n = idx+1` (wrapping):
  - `an` ← all 1s except bit n = 0, if the digit is visible; otherwise all 1s.
  - `seg` ← decode(nibble n of the `active` value that is valid after this edge).
  - `dp` ← ~`dp_en[n]`.
- Visible means `digit_en[n]` = 1 (and not suppressed, see Configuration).
- Decode is the standard common-anode hex map, 0..F. Examples: 0→0000001, 1→1001111, 2→0010010, 3→0000110, F→0111000.
- A blanked digit keeps `seg`/`dp` computed as normal but `an` all high.
- `digit_en`/`dp_en` are sampled only at `slot_tick`; changes take effect at the next slot.

## Timing
- Reset values:
  - `cnt` = 0, `idx` = 3, `shadow` = `active` = 0.
  - `an` = 1111, `seg` = 1111111, `dp` = 1.
  - `pending` = 0, `frame_tick` = 0.
- After reset release, the first `slot_tick` is at cycle REFRESH_DIV-1. On that edge `an` = 1110 (digit 0), which is also a frame boundary.
- Each digit is held for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- Write-to-display latency: at most 4·REFRESH_DIV cycles after the boundary following the write, appearing first on digit 0.
- `frame_tick` is high for the one cycle following each frame-boundary edge.
- Reset asserted mid-slot or mid-frame: every register returns to its reset value on that edge and a pending write is discarded.
- `an` never has more than one bit low. There is no overlap cycle between digits because all outputs update on the same edge.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digits 3, 2, 1 are suppressed (`an` high) when their nibble and all higher nibbles of `active` are 0.
  - Digit 0 is never suppressed.
  - Example: 0x0050 shows digits 1 and 0 only.
  - Suppression ANDs with `digit_en`.
- Not defined: only `digit_en` controls visibility; 0x0050 shows 0050.

## Structure
- Shared package `display_pkg`:
  - Segment constants for 0..F and `SEG_OFF` = 7'b1111111.
  - `AN_OFF` = 4'b1111.
  - Digit index type (2-bit).
  - A nibble-select function.
- One sub-module, `seg7_hex_decode`: combinational 4-bit to [0:6] active-low decoder, instantiated once and shared across all digits through `idx`.
- Counter, index, double buffer and output registers live in `display_scan_ctrl`.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset, then release → `an` = 1111 and `seg` = 1111111 until cycle 3; then `an` rotates 1110, 1101, 1011, 0111 every 4 cycles.
- Write 0x1230 with `digit_en` = 1111 → after the next boundary, digits 0..3 show `seg` 0000001, 0000110, 0010010, 1001111; `pending` 1→0 at the boundary; `frame_tick` pulses once per 16 cycles.
- Write 0xAAAA then 0x3210 within one frame → only 0x3210 is ever displayed; `pending` stays 1 until the boundary.
- `wr_en` on a boundary edge → old `shadow` is committed, `pending` stays 1, and the new value appears one frame later.
- `digit_en` = 0101, `dp_en` = 0001 → `an` goes low only in slots 0 and 2; `dp` = 0 only in slot 0.
- With `LEADING_ZERO_BLANK_EN`, write 0x0050 → `an` stays 1111 in slots 3 and 2. Value 0x0000 → only digit 0 is shown, as 0000001.
